// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x ID-stage blocks.
// Holds the decode sequencer state encoding.
package cv32e40x_pkg;

    typedef enum logic [0:0] {
        DEC_SEQ_IDLE,
        DEC_SEQ_SEQ
    } dec_seq_state_e;

endpackage

// File: rtl/cv32e40x_decoder_prio_mux.sv
// Combinational priority mux over parallel sub-decoder results; channel 0 wins.
// Flags illegal instructions and reports when more than one channel matched.
module cv32e40x_decoder_prio_mux
#(
    parameter int unsigned       NUM_DEC      = 4,
    parameter int unsigned       CTRL_W       = 64,
    parameter int unsigned       UOP_W        = 2,
    parameter logic [CTRL_W-1:0] CTRL_ILLEGAL = '0
) (
    input  logic [NUM_DEC-1:0]        dec_match_i,
    input  logic [NUM_DEC*CTRL_W-1:0] dec_ctrl_i,
    input  logic [NUM_DEC*UOP_W-1:0]  dec_uops_i,
    input  logic                      illegal_c_i,
    output logic [CTRL_W-1:0]         sel_ctrl_o,
    output logic [UOP_W-1:0]          sel_uops_o,
    output logic                      sel_illegal_o,
    output logic                      multi_match_o
);

    logic any_match;

    always_comb begin
        sel_ctrl_o    = CTRL_ILLEGAL;
        sel_uops_o    = '0;
        any_match     = 1'b0;
        multi_match_o = 1'b0;
        // Only the first matching channel is taken; later matches mark multi-match.
        for (int unsigned k = 0; k < NUM_DEC; k++) begin
            if (dec_match_i[k]) begin
                if (!any_match) begin
                    sel_ctrl_o = dec_ctrl_i[k*CTRL_W +: CTRL_W];
                    sel_uops_o = dec_uops_i[k*UOP_W +: UOP_W];
                end
                multi_match_o = multi_match_o | any_match;
                any_match     = 1'b1;
            end
        end
        sel_illegal_o = illegal_c_i || !any_match;
        if (sel_illegal_o) begin
            sel_ctrl_o = CTRL_ILLEGAL;
            sel_uops_o = '0;
        end
    end

endmodule

// File: rtl/cv32e40x_decode_sequencer.sv
// Registered ID decode stage: priority-muxes sub-decoders, expands multi-uop
// instructions one micro-op per handshake, with kill/halt handling.
module cv32e40x_decode_sequencer
    import cv32e40x_pkg::*;
#(
    parameter int unsigned       NUM_DEC      = 4,
    parameter int unsigned       CTRL_W       = 64,
    parameter int unsigned       UOP_W        = 2,
    parameter logic [CTRL_W-1:0] CTRL_ILLEGAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid_i,
    output logic                      if_ready_o,
    input  logic [31:0]               instr_i,
    input  logic                      illegal_c_i,
    input  logic [NUM_DEC-1:0]        dec_match_i,
    input  logic [NUM_DEC*CTRL_W-1:0] dec_ctrl_i,
    input  logic [NUM_DEC*UOP_W-1:0]  dec_uops_i,
    input  logic                      kill_i,
    input  logic                      halt_i,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    output logic [CTRL_W-1:0]         ctrl_o,
    output logic [31:0]               instr_o,
    output logic                      illegal_o,
    output logic [UOP_W-1:0]          uop_idx_o,
    output logic                      uop_last_o,
    output logic                      multi_match_o
);

    dec_seq_state_e    state_q, state_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       instr_q, instr_d;
    logic              illegal_q, illegal_d;
    logic [UOP_W-1:0]  n_q, n_d;
    logic [UOP_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic              multi_q, multi_d;

    logic [CTRL_W-1:0] mux_ctrl;
    logic [UOP_W-1:0]  mux_uops;
    logic              mux_illegal;
    logic              mux_multi;
    logic              out_free;
    logic              accept;
    logic              transfer;
    logic [UOP_W-1:0]  idx_inc;

    cv32e40x_decoder_prio_mux #(
        .NUM_DEC      (NUM_DEC),
        .CTRL_W       (CTRL_W),
        .UOP_W        (UOP_W),
        .CTRL_ILLEGAL (CTRL_ILLEGAL)
    ) u_prio_mux (
        .dec_match_i   (dec_match_i),
        .dec_ctrl_i    (dec_ctrl_i),
        .dec_uops_i    (dec_uops_i),
        .illegal_c_i   (illegal_c_i),
        .sel_ctrl_o    (mux_ctrl),
        .sel_uops_o    (mux_uops),
        .sel_illegal_o (mux_illegal),
        .multi_match_o (mux_multi)
    );

    always_comb begin
        out_free   = !valid_q || id_ready_i;
        if_ready_o = (state_q == DEC_SEQ_IDLE) && out_free && !halt_i && !kill_i;
        accept     = if_valid_i && if_ready_o;
        transfer   = valid_q && id_ready_i;
        idx_inc    = idx_q + UOP_W'(1);

        state_d   = state_q;
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        n_d       = n_q;
        idx_d     = idx_q;
        last_d    = last_q;
        multi_d   = multi_q;

        if (kill_i) begin
            state_d = DEC_SEQ_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                DEC_SEQ_IDLE: begin
                    if (accept) begin
                        ctrl_d    = mux_ctrl;
                        instr_d   = instr_i;
                        illegal_d = mux_illegal;
                        n_d       = mux_uops;
                        idx_d     = '0;
                        last_d    = (mux_uops == '0);
                        valid_d   = 1'b1;
                        multi_d   = multi_q | mux_multi;
                        state_d   = (mux_uops != '0) ? DEC_SEQ_SEQ : DEC_SEQ_IDLE;
                    end else if (transfer) begin
                        valid_d = 1'b0;
                    end
                end
                DEC_SEQ_SEQ: begin
                    // A transfer taken under halt consumes the uop but defers the
                    // index advance until halt releases (valid low meanwhile).
                    if (transfer && last_q) begin
                        valid_d = 1'b0;
                        state_d = DEC_SEQ_IDLE;
                    end else if (transfer && halt_i) begin
                        valid_d = 1'b0;
                    end else if ((transfer || !valid_q) && !halt_i) begin
                        valid_d = 1'b1;
                        idx_d   = idx_inc;
                        last_d  = (idx_inc == n_q);
                    end
                end
                default: state_d = DEC_SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DEC_SEQ_IDLE;
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_ILLEGAL;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            n_q       <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            multi_q   <= multi_d;
        end
    end

    assign id_valid_o    = valid_q;
    assign ctrl_o        = ctrl_q;
    assign instr_o       = instr_q;
    assign illegal_o     = illegal_q;
    assign uop_idx_o     = idx_q;
    assign uop_last_o    = last_q;
    assign multi_match_o = multi_q;

endmodule
